// File: rtl/dp_1024x32_fifo_ctrl.sv
// Streaming FIFO controller wrapped around a dual-port EBR with per-byte parity side bits.
// Prefetches RAM words into a 2-entry output buffer so the consumer sees 1 word/cycle.
module dp_1024x32_fifo_ctrl #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ParWidth  = 4
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic [DataWidth-1:0] InData,
    input  logic                 InValid,
    output logic                 InReady,
    output logic [DataWidth-1:0] OutData,
    output logic                 OutErr,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [AddrWidth+1:0] Level,
    output logic                 ErrSticky,
    output logic [AddrWidth-1:0] WrAddress,
    output logic [DataWidth-1:0] Data,
    output logic [ParWidth-1:0]  EDI,
    output logic                 WrEn,
    output logic [AddrWidth-1:0] RdAddress,
    output logic                 RdEn,
    input  logic [DataWidth-1:0] Q,
    input  logic [ParWidth-1:0]  EDO
);

    localparam int unsigned Depth = 2 ** AddrWidth;
    localparam int unsigned CntW  = AddrWidth + 1;
    localparam int unsigned LvlW  = AddrWidth + 2;
    localparam int unsigned EntW  = DataWidth + 1;

    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [CntW-1:0]      ram_words;
    logic                 inflight;
    logic [1:0]           occ;
    logic [EntW-1:0]      buf0;
    logic [EntW-1:0]      buf1;

    logic                 push_c;
    logic                 pop_c;
    logic                 rd_en_c;
    logic [2:0]           slots_c;
    logic                 load_err_c;
    logic [1:0]           occ_n;
    logic [EntW-1:0]      buf0_n;
    logic [EntW-1:0]      buf1_n;

    // Handshakes and RAM port drive
    assign InReady   = ResetN & (ram_words < CntW'(Depth));
    assign OutValid  = (occ != 2'd0);
    assign OutData   = buf0[DataWidth-1:0];
    assign OutErr    = buf0[DataWidth];
    assign push_c    = InValid & InReady;
    assign pop_c     = OutValid & OutReady;
    assign slots_c   = 3'(occ) + 3'(inflight) - 3'(pop_c);
    assign rd_en_c   = (ram_words != CntW'(0)) & (slots_c < 3'd2);

    assign WrEn      = push_c;
    assign Data      = InData;
    assign WrAddress = wr_ptr;
    assign RdEn      = rd_en_c;
    assign RdAddress = rd_ptr;
    assign Level     = LvlW'(ram_words) + LvlW'(inflight) + LvlW'(occ);

    // Even parity per byte on the write side
    always_comb begin
        EDI = '0;
        for (int unsigned i = 0; i < ParWidth; i++) begin
            EDI[i] = ^InData[8*i +: 8];
        end
    end

    // Parity check of the word returning from the RAM
    always_comb begin
        load_err_c = 1'b0;
        for (int unsigned i = 0; i < ParWidth; i++) begin
            load_err_c = load_err_c | ((^Q[8*i +: 8]) ^ EDO[i]);
        end
    end

    // Output buffer: pop shifts entry 1 to head, then a returning word fills the first free slot
    always_comb begin
        occ_n  = occ;
        buf0_n = buf0;
        buf1_n = buf1;
        if (pop_c) begin
            buf0_n = buf1;
            occ_n  = occ - 2'd1;
        end
        if (inflight) begin
            if (occ_n == 2'd0) begin
                buf0_n = {load_err_c, Q};
            end else begin
                buf1_n = {load_err_c, Q};
            end
            occ_n = occ_n + 2'd1;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_words <= '0;
            inflight  <= 1'b0;
            occ       <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
            ErrSticky <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AddrWidth'(1);
            end
            if (rd_en_c) begin
                rd_ptr <= rd_ptr + AddrWidth'(1);
            end
            if (push_c && !rd_en_c) begin
                ram_words <= ram_words + CntW'(1);
            end else if (!push_c && rd_en_c) begin
                ram_words <= ram_words - CntW'(1);
            end
            inflight <= rd_en_c;
            occ      <= occ_n;
            buf0     <= buf0_n;
            buf1     <= buf1_n;
            if (inflight && load_err_c) begin
                ErrSticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dp_1024x32_fifo_ctrl.sv
// Bench for dp_1024x32_fifo_ctrl: behavioural RAM, queue scoreboard, randomized traffic.
module tb_dp_1024x32_fifo_ctrl;

    logic        Clock;
    logic        ResetN;
    logic [31:0] InData;
    logic        InValid;
    logic        InReady;
    logic [31:0] OutData;
    logic        OutErr;
    logic        OutValid;
    logic        OutReady;
    logic [11:0] Level;
    logic        ErrSticky;
    logic [9:0]  WrAddress;
    logic [31:0] Data;
    logic [3:0]  EDI;
    logic        WrEn;
    logic [9:0]  RdAddress;
    logic        RdEn;
    logic [31:0] Q;
    logic [3:0]  EDO;

    dp_1024x32_fifo_ctrl dut (
        .Clock(Clock), .ResetN(ResetN),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .OutData(OutData), .OutErr(OutErr), .OutValid(OutValid), .OutReady(OutReady),
        .Level(Level), .ErrSticky(ErrSticky),
        .WrAddress(WrAddress), .Data(Data), .EDI(EDI), .WrEn(WrEn),
        .RdAddress(RdAddress), .RdEn(RdEn), .Q(Q), .EDO(EDO)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural EBR with an optional fault on EDO[2] for one address
    logic [31:0] mem     [1024];
    logic [3:0]  par_mem [1024];
    bit          corrupt_en;
    logic [9:0]  corrupt_addr;

    always @(posedge Clock) begin
        if (WrEn) begin
            mem[WrAddress]     <= Data;
            par_mem[WrAddress] <= EDI;
        end
        if (RdEn) begin
            Q   <= mem[RdAddress];
            EDO <= par_mem[RdAddress] ^ ((corrupt_en && RdAddress == corrupt_addr) ? 4'b0100 : 4'b0000);
        end
    end

    int          checks;
    int          failures;
    logic [41:0] q[$];
    int unsigned wcnt;

    typedef struct {
        bit          push;
        bit          pop;
        logic        out_valid;
        logic [31:0] out_data;
        logic        out_err;
        logic [11:0] level;
        logic        in_ready;
        logic        rd_en;
        logic [9:0]  wr_addr;
        logic [3:0]  edi;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [9:0]  exp_wr_addr;
        int          held;
    } obs_t;

    function automatic logic [3:0] par_of(input logic [31:0] w);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = (($countones(w[8*i +: 8]) % 2) == 1);
        return p;
    endfunction

    // One clock: drive, sample at negedge, advance the reference queue
    task automatic step(input logic v, input logic [31:0] d, input logic r, output obs_t o);
        logic [41:0] e;
        InValid = v; InData = d; OutReady = r;
        @(negedge Clock);
        o.out_valid   = OutValid;
        o.out_data    = OutData;
        o.out_err     = OutErr;
        o.level       = Level;
        o.in_ready    = InReady;
        o.rd_en       = RdEn;
        o.wr_addr     = WrAddress;
        o.edi         = EDI;
        o.push        = ((InValid & InReady) === 1'b1);
        o.pop         = ((OutValid & OutReady) === 1'b1);
        o.held        = q.size();
        o.exp_wr_addr = 10'(wcnt);
        o.exp_data    = 'x;
        o.exp_err     = 1'bx;
        if (o.pop && q.size() > 0) begin
            e = q.pop_front();
            o.exp_data = e[31:0];
            o.exp_err  = corrupt_en && (e[41:32] == corrupt_addr);
        end
        if (o.push) begin
            q.push_back({10'(wcnt), InData});
            wcnt++;
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_reset();
        ResetN = 1'b0; InValid = 1'b0; InData = '0; OutReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if ({InReady, OutValid, OutErr, OutData, WrEn, RdEn, Level, ErrSticky} !== 50'd0) begin
            failures++;
            $display("FAIL reset_outputs: rdy=%b vld=%b err=%b data=%h wren=%b rden=%b lvl=%0d sticky=%b, want all 0",
                     InReady, OutValid, OutErr, OutData, WrEn, RdEn, Level, ErrSticky);
        end
        ResetN = 1'b1;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", InReady);
        end
        q.delete(); wcnt = 0;
    endtask

    task automatic test_latency();
        obs_t o;
        int first_valid;
        int pops;
        first_valid = -1; pops = 0;
        for (int k = 0; k < 12; k++) begin
            step(k < 4, 32'(k + 1), 1'b1, o);
            if (o.out_valid === 1'b1 && first_valid < 0) first_valid = k;
            if (k == 0) begin
                checks++;
                if (o.rd_en !== 1'b0) begin failures++; $display("FAIL lat_empty_no_read: rden=%b want 0", o.rd_en); end
            end
            if (k == 1) begin
                checks++;
                if (o.rd_en !== 1'b1) begin failures++; $display("FAIL lat_read_issue: rden=%b want 1", o.rd_en); end
            end
            if (o.pop) begin
                pops++;
                checks++;
                if ({o.out_err, o.out_data} !== {o.exp_err, o.exp_data}) begin
                    failures++;
                    $display("FAIL lat_pop: got err=%b data=%h want err=%b data=%h", o.out_err, o.out_data, o.exp_err, o.exp_data);
                end
            end
            if (k == 11) begin
                checks++;
                if (o.level !== 12'd0) begin failures++; $display("FAIL lat_level_end: got %0d want 0", o.level); end
            end
        end
        checks++;
        if (first_valid != 3) begin failures++; $display("FAIL lat_first_valid: got step %0d want 3", first_valid); end
        checks++;
        if (pops != 4) begin failures++; $display("FAIL lat_pop_count: got %0d want 4", pops); end
    endtask

    task automatic test_parity();
        obs_t o;
        logic [31:0] d;
        int n;
        step(1'b1, 32'hA5A5A5A5, 1'b1, o);
        checks++;
        if (!o.push || o.edi !== 4'b0000) begin failures++; $display("FAIL par_a5: push=%b edi=%b want 1/0000", o.push, o.edi); end
        step(1'b1, 32'h01000001, 1'b1, o);
        checks++;
        if (!o.push || o.edi !== 4'b1001) begin failures++; $display("FAIL par_0100: push=%b edi=%b want 1/1001", o.push, o.edi); end
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            step(1'b1, d, 1'b1, o);
            checks++;
            if (!o.push || o.edi !== par_of(d) || o.wr_addr !== o.exp_wr_addr) begin
                failures++;
                $display("FAIL par_rand: push=%b edi=%b addr=%0d want 1/%b/%0d", o.push, o.edi, o.wr_addr, par_of(d), o.exp_wr_addr);
            end
            if (o.pop) begin
                checks++;
                if ({o.out_err, o.out_data} !== {o.exp_err, o.exp_data}) begin
                    failures++;
                    $display("FAIL par_pop: got err=%b data=%h want err=%b data=%h", o.out_err, o.out_data, o.exp_err, o.exp_data);
                end
            end
        end
        n = 0;
        while (q.size() != 0 && n < 50) begin
            step(1'b0, '0, 1'b1, o);
            n++;
            if (o.pop) begin
                checks++;
                if ({o.out_err, o.out_data} !== {o.exp_err, o.exp_data}) begin
                    failures++;
                    $display("FAIL par_drain: got err=%b data=%h want err=%b data=%h", o.out_err, o.out_data, o.exp_err, o.exp_data);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL par_drain_timeout: %0d words left want 0", q.size()); end
    endtask

    task automatic test_full();
        obs_t o;
        int accepted;
        int n;
        accepted = 0;
        for (int k = 0; k < 1100; k++) begin
            step(1'b1, $urandom, 1'b0, o);
            if (o.push) accepted++;
        end
        checks++;
        if (accepted != 1026) begin failures++; $display("FAIL full_accepted: got %0d want 1026", accepted); end
        checks++;
        if (o.in_ready !== 1'b0 || o.level !== 12'd1026) begin
            failures++;
            $display("FAIL full_state: rdy=%b lvl=%0d want 0/1026", o.in_ready, o.level);
        end
        n = 0;
        while (q.size() != 0 && n < 1200) begin
            step(1'b0, '0, 1'b1, o);
            if (n == 0) begin
                checks++;
                if (o.rd_en !== 1'b1 || o.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL full_read_same_cycle: rden=%b rdy=%b want 1/0", o.rd_en, o.in_ready);
                end
            end
            if (n == 1) begin
                checks++;
                if (o.in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_read: got %b want 1", o.in_ready); end
            end
            n++;
            if (o.pop) begin
                checks++;
                if ({o.out_err, o.out_data} !== {o.exp_err, o.exp_data}) begin
                    failures++;
                    $display("FAIL full_drain: got err=%b data=%h want err=%b data=%h", o.out_err, o.out_data, o.exp_err, o.exp_data);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL full_drain_timeout: %0d words left want 0", q.size()); end
        // Pointers have wrapped; the next write address must follow the push count modulo depth
        step(1'b1, 32'h0BADF00D, 1'b1, o);
        checks++;
        if (!o.push || o.wr_addr !== o.exp_wr_addr) begin
            failures++;
            $display("FAIL full_wrap_addr: push=%b addr=%0d want 1/%0d", o.push, o.wr_addr, o.exp_wr_addr);
        end
    endtask

    task automatic test_parity_error();
        obs_t o;
        int errs;
        int n;
        checks++;
        if (ErrSticky !== 1'b0) begin failures++; $display("FAIL err_sticky_pre: got %b want 0", ErrSticky); end
        corrupt_addr = 10'(wcnt + 2 + q.size() - q.size());
        corrupt_addr = 10'(wcnt + 2);
        corrupt_en   = 1'b1;
        errs = 0; n = 0;
        while ((n < 5 || q.size() != 0) && n < 60) begin
            step(n < 5, $urandom, 1'b1, o);
            n++;
            if (o.pop) begin
                if (o.out_err === 1'b1) errs++;
                checks++;
                if ({o.out_err, o.out_data} !== {o.exp_err, o.exp_data}) begin
                    failures++;
                    $display("FAIL err_pop: got err=%b data=%h want err=%b data=%h", o.out_err, o.out_data, o.exp_err, o.exp_data);
                end
            end
        end
        corrupt_en = 1'b0;
        checks++;
        if (errs != 1 || ErrSticky !== 1'b1) begin
            failures++;
            $display("FAIL err_count_sticky: errs=%0d sticky=%b want 1/1", errs, ErrSticky);
        end
        n = 0;
        while ((n < 3 || q.size() != 0) && n < 40) begin
            step(n < 3, $urandom, 1'b1, o);
            n++;
            if (o.pop) begin
                checks++;
                if ({o.out_err, o.out_data} !== {o.exp_err, o.exp_data}) begin
                    failures++;
                    $display("FAIL err_clean_pop: got err=%b data=%h want err=%b data=%h", o.out_err, o.out_data, o.exp_err, o.exp_data);
                end
            end
        end
        checks++;
        if (ErrSticky !== 1'b1 || q.size() != 0) begin
            failures++;
            $display("FAIL err_sticky_hold: sticky=%b left=%0d want 1/0", ErrSticky, q.size());
        end
    endtask

    task automatic test_random_stream();
        obs_t o;
        int n;
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)), o);
            checks++;
            if (o.level !== 12'(o.held)) begin failures++; $display("FAIL rnd_level: got %0d want %0d", o.level, o.held); end
            if (o.held < 1024) begin
                checks++;
                if (o.in_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready: got %b want 1 at level %0d", o.in_ready, o.held); end
            end
            if (o.pop) begin
                checks++;
                if ({o.out_err, o.out_data} !== {o.exp_err, o.exp_data}) begin
                    failures++;
                    $display("FAIL rnd_pop: got err=%b data=%h want err=%b data=%h", o.out_err, o.out_data, o.exp_err, o.exp_data);
                end
            end
        end
        n = 0;
        while (q.size() != 0 && n < 1200) begin
            step(1'b0, '0, 1'b1, o);
            n++;
            if (o.pop) begin
                checks++;
                if ({o.out_err, o.out_data} !== {o.exp_err, o.exp_data}) begin
                    failures++;
                    $display("FAIL rnd_drain: got err=%b data=%h want err=%b data=%h", o.out_err, o.out_data, o.exp_err, o.exp_data);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL rnd_drain_timeout: %0d words left want 0", q.size()); end
    endtask

    task automatic test_reset_midop();
        obs_t o;
        int n;
        bit seen;
        for (int k = 0; k < 10; k++) step(k < 6, $urandom, 1'b0, o);
        step(1'b0, '0, 1'b1, o);
        checks++;
        if (!o.pop || o.rd_en !== 1'b1) begin failures++; $display("FAIL mid_read_launch: pop=%b rden=%b want 1/1", o.pop, o.rd_en); end
        InValid = 1'b1; InData = 32'hFFFF0000; OutReady = 1'b0;
        #2;
        ResetN = 1'b0;
        #1;
        checks++;
        if ({InReady, OutValid, OutErr, WrEn, RdEn, ErrSticky} !== 6'd0) begin
            failures++;
            $display("FAIL mid_reset_flags: rdy=%b vld=%b err=%b wren=%b rden=%b sticky=%b want all 0",
                     InReady, OutValid, OutErr, WrEn, RdEn, ErrSticky);
        end
        checks++;
        if (OutData !== 32'd0 || Level !== 12'd0) begin
            failures++;
            $display("FAIL mid_reset_data: data=%h lvl=%0d want 0/0", OutData, Level);
        end
        InValid = 1'b0;
        @(posedge Clock); #1;
        ResetN = 1'b1;
        q.delete(); wcnt = 0;
        step(1'b1, 32'h5EED1234, 1'b1, o);
        checks++;
        if (!o.push || o.wr_addr !== 10'd0) begin failures++; $display("FAIL mid_first_push: push=%b addr=%0d want 1/0", o.push, o.wr_addr); end
        n = 0; seen = 0;
        while (n < 12) begin
            step(1'b0, '0, 1'b1, o);
            n++;
            if (o.pop) begin
                seen = 1;
                checks++;
                if ({o.out_err, o.out_data} !== {o.exp_err, o.exp_data}) begin
                    failures++;
                    $display("FAIL mid_pop: got err=%b data=%h want err=%b data=%h", o.out_err, o.out_data, o.exp_err, o.exp_data);
                end
            end
        end
        checks++;
        if (!seen || o.level !== 12'd0) begin failures++; $display("FAIL mid_drain: seen=%b lvl=%0d want 1/0", seen, o.level); end
    endtask

    initial begin
        checks = 0; failures = 0; wcnt = 0;
        corrupt_en = 1'b0; corrupt_addr = '0;
        test_reset();
        test_latency();
        test_parity();
        test_full();
        test_parity_error();
        test_random_stream();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dp_1024x32_fifo_ctrl.md
# dp_1024x32_fifo_ctrl

Single-clock FIFO controller that turns the 1024x32 dual-port EBR block (with its 4-bit EDI/EDO side bits) into a streaming ring buffer. It sits directly around the RAM: it drives the write port from an upstream valid/ready stream, drives the read port to prefetch into a 2-entry output buffer for the downstream valid/ready consumer, and generates and checks per-byte parity on the EDI/EDO bits. WrClock and RdClock of the RAM are both tied to Clock at the level above.

## Interface
Parameters:
- AddrWidth, 10, RAM address width; Depth = 2**AddrWidth
- DataWidth, 32, word width; must be a multiple of 8
- ParWidth, 4, parity bits = DataWidth/8

Ports:
- Clock  in  1  single clock for all logic and both RAM ports
- ResetN  in  1  asynchronous, active-low reset
- InData  in  DataWidth  upstream word
- InValid  in  1  upstream word valid
- InReady  out  1  block accepts a word this cycle
- OutData  out  DataWidth  downstream word
- OutErr  out  1  parity error flag aligned with OutData
- OutValid  out  1  OutData/OutErr valid
- OutReady  in  1  downstream accepts
- Level  out  AddrWidth+2  words held (RAM + in-flight read + output buffer)
- ErrSticky  out  1  set on any parity error, cleared only by reset
- WrAddress  out  AddrWidth  to RAM
- Data  out  DataWidth  to RAM
- EDI  out  ParWidth  parity to RAM
- WrEn  out  1  to RAM
- RdAddress  out  AddrWidth  to RAM
- RdEn  out  1  to RAM
- Q  in  DataWidth  from RAM
- EDO  in  ParWidth  from RAM

## Operation
- Write: push = InValid & InReady. WrEn = push, Data = InData, WrAddress = wr_ptr (combinational); wr_ptr increments on push, wraps Depth-1 -> 0.
- EDI[i] = XOR of InData[8i+7:8i] (even parity per byte).
- ram_words: words written but not yet read from RAM; +1 on push, -1 on RdEn, both -> unchanged. InReady = ResetN & (ram_words < Depth).
- Read/prefetch: output buffer holds 0..2 entries (occ); inflight = 1 if RdEn asserted last cycle. pop = OutValid & OutReady.
- RdEn = (ram_words > 0) & (occ + inflight - pop < 2). RdAddress = rd_ptr; rd_ptr increments on RdEn, wraps.
- A word written at edge E is readable from the cycle after E (no same-address read/write collision possible; no bypass).
- Returning data: in the cycle after RdEn, Q/EDO are valid; word and err = OR over i of (XOR(Q byte i) ^ EDO[i]) are loaded into the output buffer at the next edge.
- Output buffer is FIFO-ordered; OutValid = (occ > 0); OutData/OutErr = head entry. Head held stable while OutValid & ~OutReady.
- ErrSticky sets when an entry with err=1 is loaded.
- Level = ram_words + inflight + occ.

## Timing
- Reset (ResetN low, asynchronous): wr_ptr, rd_ptr, ram_words, occ, inflight = 0; InReady 0, OutValid 0, OutErr 0, OutData 0, WrEn 0, RdEn 0, Level 0, ErrSticky 0. Reset mid-operation discards all data including an in-flight read; RAM contents are ignored afterward.
- First cycle after release: InReady 1.
- Latency: push at edge E0 -> RdEn high in cycle after E0 -> OutValid high after E2 (2 cycles, empty FIFO, OutReady high).
- Throughput: 1 word/cycle sustained in and out simultaneously.
- Full: ram_words = Depth -> InReady 0; simultaneous RdEn does not raise InReady in the same cycle (registered count).
- Empty: ram_words = 0 -> RdEn 0; push in same cycle not read until next cycle.
- Backpressure: OutReady low -> at most 2 buffered + 0 in-flight once settled; no overwrite, no drop.

## Test plan
- Reset then push 0x00000001..0x00000004 back-to-back, OutReady=1 -> OutValid first high 2 cycles after first push, data out in order, OutErr 0, Level returns to 0.
- Push 1024 words with OutReady=0 -> after 1026 accepted total (1024 RAM + 2 buffer drained from RAM) InReady 0 at ram_words=1024; Level=1026; then drain all -> correct order, wr_ptr/rd_ptr wrapped.
- Push 0xA5A5A5A5 -> EDI = 4'b0000; push 0x01000001 -> EDI = 4'b1001.
- Bench model corrupts EDO[2] on read of one word -> that word exits with OutErr 1, ErrSticky 1 and remains 1; other words OutErr 0.
- Continuous push/pop for 3000 cycles with random OutReady -> no loss/duplication, InReady never 0 while ram_words < 1024.
- Assert ResetN low with 5 words held and a read in flight -> all outputs at reset values immediately; after release first new push emerges with correct data.
